// File: rtl/piso_pkg.sv
// Shared types and helpers for the nibble-chained PISO transmitter.
// State encoding, nibble size and counter sizing live here.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int PISO_NIBBLE = 4;

    function automatic int piso_cnt_w(input int width, input int gap);
        int m;
        m = (width > gap) ? width : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/piso_shifter.sv
// WIDTH-bit load/shift register built from WIDTH/4 nibble stages.
// Shifts right with zero fill; q0 is the bit presented to the wire.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    localparam int NS = WIDTH / PISO_NIBBLE;

    logic [PISO_NIBBLE-1:0] nib [NS];
    logic                   chain [NS+1];

    // chain[i] is the bit leaving stage i toward stage i-1
    assign chain[NS] = 1'b0;

    for (genvar i = 0; i < NS; i++) begin : g_stage
        assign chain[i] = nib[i][0];

        always_ff @(posedge clk) begin
            if (!rst || clr) begin
                nib[i] <= '0;
            end else if (ld) begin
                nib[i] <= d[i*PISO_NIBBLE +: PISO_NIBBLE];
            end else if (sh) begin
                nib[i] <= {chain[i+1], nib[i][PISO_NIBBLE-1:1]};
            end
        end
    end

    assign q0 = chain[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serial-transmit controller: handshake, shift sequencing, idle gap.
// Optional even-parity trailer bit enabled with PISO_PARITY_EN.
module piso_tx_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             sout,
    output logic             frame,
    output logic             done,
    output logic             busy
);

    localparam int CW = piso_cnt_w(WIDTH, GAP);
`ifdef PISO_PARITY_EN
    localparam int LASTI = WIDTH;
`else
    localparam int LASTI = WIDTH - 1;
`endif
    localparam logic [CW-1:0] LAST  = CW'(LASTI);
    localparam logic [CW-1:0] GLAST = CW'((GAP > 0) ? GAP - 1 : 0);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ld, sh, clr;
    logic          q0;
    logic          bitv;

    piso_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .sh  (sh),
        .clr (clr),
        .d   (in_data),
        .q0  (q0)
    );

`ifdef PISO_PARITY_EN
    logic par;

    always_ff @(posedge clk) begin
        if (!rst) begin
            par <= 1'b0;
        end else if (ld) begin
            par <= ^in_data;
        end else if (clr) begin
            par <= 1'b0;
        end
    end

    assign bitv = (cnt == LAST) ? par : q0;
`else
    assign bitv = q0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ld       = 1'b0;
        sh       = 1'b0;
        clr      = 1'b0;
        in_ready = 1'b0;
        sout     = 1'b0;
        frame    = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = rst & ~abort;
                if (in_valid && rst && !abort) begin
                    ld      = 1'b1;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                frame = 1'b1;
                sout  = bitv;
                if (abort) begin
                    clr     = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == LAST) begin
                    sh      = 1'b1;
                    done    = rst;
                    cnt_n   = '0;
                    state_n = (GAP > 0) ? piso_pkg::GAP : IDLE;
                end else begin
                    sh    = 1'b1;
                    cnt_n = cnt + 1'b1;
                end
            end
            piso_pkg::GAP: begin
                if (abort) begin
                    clr     = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == GLAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed self-checking bench for piso_tx_ctrl (WIDTH=20, GAP=1).
// Honours PISO_PARITY_EN for the parity trailer expectations.
module tb_piso_tx_ctrl;

    localparam int WIDTH = 20;
    localparam int GAP   = 1;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L = WIDTH + PAR;
    localparam int P = L + GAP + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             abort;
    logic             sout;
    logic             frame;
    logic             done;
    logic             busy;

    piso_tx_ctrl #(
        .WIDTH (WIDTH),
        .GAP   (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .abort    (abort),
        .sout     (sout),
        .frame    (frame),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    logic fr [64];
    logic so [64];
    logic dn [64];
    logic by [64];
    logic rd [64];

    int nf, nd, nb, rdy_at, leak, done_at, done_first;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records one sample per cycle starting with the current cycle
    task automatic capture(input int n, input int drop);
        for (int c = 1; c <= n; c++) begin
            fr[c] = frame;
            so[c] = sout;
            dn[c] = done;
            by[c] = busy;
            rd[c] = in_ready;
            if (c == drop) in_valid = 1'b0;
            step();
        end
    endtask

    task automatic tally(input int n);
        nf = 0; nd = 0; nb = 0; rdy_at = 0;
        leak = 0; done_at = 0; done_first = 0;
        for (int c = 1; c <= n; c++) begin
            if (fr[c]) nf++;
            if (so[c] && !fr[c]) leak++;
            if (dn[c]) begin
                nd++;
                done_at = c;
                if (done_first == 0) done_first = c;
            end
            if (by[c]) nb++;
            if (rd[c] && rdy_at == 0) rdy_at = c;
        end
    endtask

    function automatic logic [31:0] bits_from(input int s);
        logic [31:0] b;
        b = '0;
        for (int k = 0; k < L; k++) b[k] = so[s+k];
        return b;
    endfunction

    function automatic logic [31:0] expw(input logic [19:0] d);
        logic [31:0] w;
        w = {12'b0, d};
        if (PAR == 1) w[20] = ^d;
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        abort    = 1'b0;
        step();
        step();
        chk("rst_ready", in_ready, 0);
        chk("rst_frame", frame, 0);
        rst = 1'b1;
        #1;
        chk("rel_ready", in_ready, 1);
        chk("rel_sout", sout, 0);
        chk("rel_frame", frame, 0);
        chk("rel_done", done, 0);
        chk("rel_busy", busy, 0);

        // single word, in_data changes after accept
        in_valid = 1'b1;
        in_data  = 20'hA5C3F;
        step();
        in_valid = 1'b0;
        in_data  = 20'h0;
        capture(L + 4, 0);
        tally(L + 4);
        chk("w1_bits", bits_from(1), expw(20'hA5C3F));
        chk("w1_nframe", nf, L);
        chk("w1_ndone", nd, 1);
        chk("w1_done_at", done_at, L);
        chk("w1_busy", nb, L + GAP);
        chk("w1_ready_at", rdy_at, P);
        chk("w1_leak", leak, 0);

        // two words, valid held
        in_valid = 1'b1;
        in_data  = 20'h00001;
        step();
        in_data = 20'h80000;
        capture(2 * P + 2, P + 3);
        tally(2 * P + 2);
        chk("w2a_bits", bits_from(1), expw(20'h00001));
        chk("w2b_bits", bits_from(P + 1), expw(20'h80000));
        chk("w2_nframe", nf, 2 * L);
        chk("w2_ndone", nd, 2);
        chk("w2_done1", done_first, L);
        chk("w2_done2", done_at, P + L);
        chk("w2_gap_fr", fr[L+1], 0);
        chk("w2_idle_fr", fr[P], 0);
        chk("w2_start_fr", fr[P+1], 1);
        chk("w2_ready_at", rdy_at, P);
        chk("w2_leak", leak, 0);

        // abort on frame cycle 10
        in_valid = 1'b1;
        in_data  = 20'hFFFFF;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        chk("ab_fr10", frame, 1);
        chk("ab_so10", sout, 1);
        abort = 1'b1;
        #1;
        chk("ab_done10", done, 0);
        step();
        abort = 1'b0;
        #1;
        chk("ab_frame", frame, 0);
        chk("ab_sout", sout, 0);
        chk("ab_busy", busy, 0);
        chk("ab_ready", in_ready, 1);
        capture(L + 2, 0);
        tally(L + 2);
        chk("ab_nframe", nf, 0);
        chk("ab_ndone", nd, 0);

        // abort on the would-be last bit
        in_valid = 1'b1;
        in_data  = 20'h12345;
        step();
        in_valid = 1'b0;
        repeat (L - 1) step();
        chk("abl_frame", frame, 1);
        chk("abl_done_pre", done, 1);
        abort = 1'b1;
        #1;
        chk("abl_done", done, 0);
        step();
        abort = 1'b0;
        #1;
        chk("abl_busy", busy, 0);
        chk("abl_frame_n", frame, 0);

        // reset mid-word at frame cycle 5
        in_valid = 1'b1;
        in_data  = 20'hFFFFF;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("rm_fr5", frame, 1);
        rst = 1'b0;
        #1;
        chk("rm_ready_lo", in_ready, 0);
        step();
        rst = 1'b1;
        #1;
        chk("rm_frame", frame, 0);
        chk("rm_sout", sout, 0);
        chk("rm_done", done, 0);
        chk("rm_busy", busy, 0);
        chk("rm_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 20'h00003;
        step();
        in_valid = 1'b0;
        capture(L + 4, 0);
        tally(L + 4);
        chk("rm_first", so[1], 1);
        chk("rm_bits", bits_from(1), expw(20'h00003));
        chk("rm_nframe", nf, L);
        chk("rm_ndone", nd, 1);

        // abort and valid together in IDLE
        in_valid = 1'b1;
        abort    = 1'b1;
        in_data  = 20'h0000F;
        #1;
        chk("ai_ready", in_ready, 0);
        step();
        chk("ai_busy", busy, 0);
        chk("ai_frame", frame, 0);
        abort = 1'b0;
        #1;
        chk("ai_ready2", in_ready, 1);
        step();
        in_valid = 1'b0;
        capture(L + 4, 0);
        tally(L + 4);
        chk("ai_first", so[1], 1);
        chk("ai_bits", bits_from(1), expw(20'h0000F));
        chk("ai_nframe", nf, L);
        chk("ai_done_at", done_at, L);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
Serial-transmit controller for the 20-bit nibble-chained parallel-in/serial-out datapath.
- Accepts a parallel word over a valid/ready handshake and loads it into the shifter.
- Sequences exactly WIDTH shift cycles, LSB first, with a frame qualifier and a completion pulse.
- Inserts a programmable idle gap between words.
- Sits between a word producer and a single-wire serial sink.

Parameters:
WIDTH, 20, serial word length in bits (multiple of 4, >= 4)
GAP, 1, idle cycles forced after each word (0 allowed, 0..255)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  producer presents in_data
in_data  in  WIDTH  parallel word to transmit
in_ready  out  1  controller can accept a word this cycle
abort  in  1  synchronous cancel of the current word
sout  out  1  serial data, bit 0 first
frame  out  1  high while sout carries a valid data bit
done  out  1  one-cycle pulse on the last bit of a word
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, shift register=0, counter=0. In the cycle after release: sout=0, frame=0, done=0, busy=0, in_ready=1.
- in_ready is low while rst==0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, sout=0, frame=0.
  - Accept = in_valid & in_ready & ~abort.
  - On accept: the shifter loads in_data at the edge, cnt=0, next=SHIFT.
- SHIFT:
  - frame=1, sout=shreg[0]; each edge shifts right with 0 fill and increments cnt.
  - When cnt==WIDTH-1: done=1 in that cycle; next=GAP if GAP>0, else IDLE.
- GAP:
  - sout=0, frame=0; cnt counts 0..GAP-1, then next=IDLE.
- Latency and throughput:
  - Bit k of the accepted word appears on sout k+1 cycles after the accept edge.
  - Minimum word period is WIDTH+GAP+1 cycles.
  - in_ready is low for the whole of SHIFT and GAP; there is no back-to-back accept during SHIFT.
- in_data is sampled only on the accept edge; later changes to in_data have no effect.
- abort:
  - In SHIFT or GAP: next=IDLE, shifter cleared, no done pulse (including on the would-be last bit).
  - In IDLE: in_ready=0 for that cycle, no accept.
  - abort wins over accept when both occur in the same cycle.
- sout is forced to 0 whenever frame==0.
- Counter width: $clog2(max(WIDTH,GAP)+1); it must not wrap inside a state.
- Reset mid-word: frame drops the cycle after reset is sampled, no done pulse.

Optional Feature:
PISO_PARITY_EN
- Defined:
  - After bit WIDTH-1, one extra SHIFT cycle drives the even parity (XOR of the loaded word) on sout with frame=1.
  - done moves to the parity cycle; word period becomes WIDTH+GAP+2.
  - Parity is computed at load and held in a flop.
  - abort during the parity cycle suppresses done.
- Undefined: no parity cycle; behaviour exactly as above.

Decomposition:
- Shared package piso_pkg holds:
  - state enum (IDLE, SHIFT, GAP),
  - constant PISO_NIBBLE=4,
  - count-width helper function.
- Sub-module piso_shifter holds:
  - the WIDTH-bit load/shift register, built from WIDTH/4 nibble stages,
  - ports: clk, rst, ld, sh, clr, d, q0.
- The FSM, counter and handshake stay in piso_tx_ctrl.

Test Plan:
- Reset, then in_valid=1 with in_data=20'hA5C3F (GAP=1) -> sout over 20 frame cycles = 1111 1100 0011 1010 0101; done on the 20th; busy for 21 cycles; in_ready=1 again 22 cycles after the accept edge.
- Two words 20'h00001 and 20'h80000 held valid continuously -> each has exactly 20 frame cycles, 1 gap cycle between them; second word starts 22 cycles after the first accept; sout=1 only on bit 0 of the first word and bit 19 of the second.
- abort pulsed on frame cycle 10 of 20'hFFFFF -> frame and sout 0 next cycle, no done; in_ready=1 the cycle after abort.
- rst=0 for one cycle at frame cycle 5 -> all outputs 0 after the edge; in_valid then held with rst high -> new word accepted; first sout is its bit 0.
- abort and in_valid together in IDLE -> in_ready=0, no load; next cycle accepts with abort=0.
- With PISO_PARITY_EN, word 20'hA5C3F -> 21 frame cycles; 21st sout=0 (popcount 12); word 20'h00001 -> 21st sout=1; done on cycle 21.
